// File: rtl/user_pos_ctl.sv
// user_pos_ctl: position controller for the user sprite.
// Once every MOVE_DIV frames it samples the debounced direction buttons and
// builds a candidate position clamped to the screen. It asks the maze
// checker about that candidate over a req/ack handshake. The candidate is
// committed to x_pos/y_pos only when the checker reports no collision.
// Optional build macro: USER_DIAG_MOVE_EN
//   defined   - both axes may move in the same tick as one diagonal candidate
//   undefined - one axis per tick, priority up > down > left > right
module user_pos_ctl #(
  parameter int X_INIT      = 100,
  parameter int Y_INIT      = 100,
  parameter int STEP        = 4,
  parameter int MOVE_DIV    = 2,
  parameter int X_MAX       = 924,
  parameter int Y_MAX       = 668,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        chk_ack,
  input  logic        chk_blocked,
  output logic        chk_req,
  output logic [11:0] chk_x,
  output logic [11:0] chk_y,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        moved,
  output logic        blocked
);

  localparam logic [12:0] STEP_W   = 13'(STEP);
  localparam logic [12:0] X_MAX_W  = 13'(X_MAX);
  localparam logic [12:0] Y_MAX_W  = 13'(Y_MAX);
  localparam logic [11:0] X_INIT_W = 12'(X_INIT);
  localparam logic [11:0] Y_INIT_W = 12'(Y_INIT);
  localparam logic [3:0]  DIV_LAST = 4'(MOVE_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_QUERY,
    ST_COMMIT
  } state_t;

  state_t      state_reg, state_next;
  logic        vsync_prev_reg;
  logic        frame_tick_reg;
  logic [3:0]  div_reg;
  logic        div_wrap;
  logic        move_tick;
  logic [7:0]  cnt_reg, cnt_next;
  logic [11:0] chk_x_reg, chk_x_next;
  logic [11:0] chk_y_reg, chk_y_next;
  logic [11:0] x_pos_reg, x_pos_next;
  logic [11:0] y_pos_reg, y_pos_next;
  logic        moved_reg, moved_next;
  logic        blocked_reg, blocked_next;

  // Buttons ordered {right, left, down, up}; each axis is an opposing pair.
  logic [3:0]  btn_vec;
  logic [3:0]  btn_eff;
  logic        use_x, use_y;
  logic [12:0] x_ext, y_ext;
  logic [12:0] x_dec_sat, x_inc_sat, y_dec_sat, y_inc_sat;
  logic [11:0] cand_x, cand_y;

  assign btn_vec = {btn_right, btn_left, btn_down, btn_up};

  // Opposing buttons on the same axis cancel out.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis_cancel
      assign btn_eff[2*gi]   = btn_vec[2*gi]   & ~btn_vec[2*gi+1];
      assign btn_eff[2*gi+1] = btn_vec[2*gi+1] & ~btn_vec[2*gi];
    end
  endgenerate

  // Frame tick detection and the frame divider that produces move ticks.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vsync_prev_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
      div_reg        <= 4'd0;
    end else begin
      vsync_prev_reg <= vsync_in;
      frame_tick_reg <= vsync_in & ~vsync_prev_reg;
      if (frame_tick_reg) begin
        div_reg <= div_wrap ? 4'd0 : div_reg + 4'd1;
      end
    end
  end

  assign div_wrap  = (div_reg == DIV_LAST);
  assign move_tick = frame_tick_reg & div_wrap;

  // Candidate position: 13-bit arithmetic so neither direction can wrap.
  always_comb begin
    x_ext     = {1'b0, x_pos_reg};
    y_ext     = {1'b0, y_pos_reg};
    x_dec_sat = (x_ext < STEP_W) ? 13'd0 : x_ext - STEP_W;
    y_dec_sat = (y_ext < STEP_W) ? 13'd0 : y_ext - STEP_W;
    x_inc_sat = x_ext + STEP_W;
    y_inc_sat = y_ext + STEP_W;
    if (x_inc_sat > X_MAX_W) x_inc_sat = X_MAX_W;
    if (y_inc_sat > Y_MAX_W) y_inc_sat = Y_MAX_W;

    use_y = btn_eff[0] | btn_eff[1];
`ifdef USER_DIAG_MOVE_EN
    use_x = btn_eff[2] | btn_eff[3];
`else
    use_x = ~use_y & (btn_eff[2] | btn_eff[3]);
`endif

    cand_y = y_pos_reg;
    if (use_y) begin
      cand_y = btn_eff[0] ? y_dec_sat[11:0] : y_inc_sat[11:0];
    end
    cand_x = x_pos_reg;
    if (use_x) begin
      cand_x = btn_eff[2] ? x_dec_sat[11:0] : x_inc_sat[11:0];
    end
  end

  // Move sequencer: next state plus next values of all held outputs.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    chk_x_next   = chk_x_reg;
    chk_y_next   = chk_y_reg;
    x_pos_next   = x_pos_reg;
    y_pos_next   = y_pos_reg;
    moved_next   = 1'b0;
    blocked_next = blocked_reg;
    case (state_reg)
      ST_IDLE: begin
        if (move_tick) state_next = ST_CALC;
      end
      ST_CALC: begin
        // Nothing to ask about when the sprite would stay where it is.
        if (cand_x == x_pos_reg && cand_y == y_pos_reg) begin
          state_next = ST_IDLE;
        end else begin
          chk_x_next = cand_x;
          chk_y_next = cand_y;
          cnt_next   = 8'd0;
          state_next = ST_QUERY;
        end
      end
      ST_QUERY: begin
        // An ack on the final timeout cycle still counts as an answer.
        if (chk_ack) begin
          blocked_next = chk_blocked;
          cnt_next     = 8'd0;
          state_next   = ST_COMMIT;
        end else if (cnt_reg == CNT_LAST) begin
          blocked_next = 1'b1;
          cnt_next     = 8'd0;
          state_next   = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_COMMIT: begin
        if (!blocked_reg) begin
          x_pos_next = chk_x_reg;
          y_pos_next = chk_y_reg;
          moved_next = 1'b1;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 8'd0;
      chk_x_reg   <= X_INIT_W;
      chk_y_reg   <= Y_INIT_W;
      x_pos_reg   <= X_INIT_W;
      y_pos_reg   <= Y_INIT_W;
      moved_reg   <= 1'b0;
      blocked_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      chk_x_reg   <= chk_x_next;
      chk_y_reg   <= chk_y_next;
      x_pos_reg   <= x_pos_next;
      y_pos_reg   <= y_pos_next;
      moved_reg   <= moved_next;
      blocked_reg <= blocked_next;
    end
  end

  assign chk_req = (state_reg == ST_QUERY);
  assign chk_x   = chk_x_reg;
  assign chk_y   = chk_y_reg;
  assign x_pos   = x_pos_reg;
  assign y_pos   = y_pos_reg;
  assign moved   = moved_reg;
  assign blocked = blocked_reg;

endmodule

// File: tb/tb_user_pos_ctl.sv
// tb_user_pos_ctl: directed bench for user_pos_ctl with a behavioural
// maze checker that answers each query after a fixed delay.
module tb_user_pos_ctl;

  // x starts off the 4-pixel grid so that walking right lands on 922
  // and the following step has to saturate at 924.
  localparam int X0      = 102;
  localparam int Y0      = 100;
  localparam int ACK_DLY = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_in = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        chk_ack = 1'b0, chk_blocked = 1'b0;
  logic        chk_req;
  logic [11:0] chk_x, chk_y, x_pos, y_pos;
  logic        moved, blocked;

  int check_count = 0;
  int error_count = 0;

  // checker model state
  bit ack_en = 1'b1;
  bit resp_blocked = 1'b0;
  bit late_ack = 1'b0;
  int req_age = 0;
  int req_count = 0;
  int req_cycles = 0;
  int moved_count = 0;
  int last_cx = 0, last_cy = 0;

  int ex, ey, base_req, base_mov, base_cyc;
  bit seen;

  user_pos_ctl #(
    .X_INIT(X0), .Y_INIT(Y0), .STEP(4), .MOVE_DIV(2),
    .X_MAX(924), .Y_MAX(668), .ACK_TIMEOUT(15)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync_in(vsync_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .chk_ack(chk_ack), .chk_blocked(chk_blocked), .chk_req(chk_req),
    .chk_x(chk_x), .chk_y(chk_y), .x_pos(x_pos), .y_pos(y_pos),
    .moved(moved), .blocked(blocked)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input int got, input int exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Checker model: samples the DUT on the falling edge, acks after ACK_DLY.
  always @(negedge pclk) begin
    chk_ack = 1'b0;
    if (late_ack) begin
      chk_ack = 1'b1;
      chk_blocked = resp_blocked;
    end
    if (moved) moved_count++;
    if (chk_req) begin
      if (req_age == 0) begin
        req_count++;
        last_cx = int'(chk_x);
        last_cy = int'(chk_y);
      end
      req_age++;
      req_cycles++;
      if (ack_en && req_age == ACK_DLY) begin
        chk_ack = 1'b1;
        chk_blocked = resp_blocked;
      end
    end else begin
      req_age = 0;
    end
  end

  // One 10-cycle frame: vsync high for 4 cycles, low for 6.
  task automatic frame();
    @(negedge pclk);
    vsync_in = 1'b1;
    repeat (4) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (5) @(negedge pclk);
  endtask

  task automatic move_period();
    frame();
    frame();
    repeat (2) @(negedge pclk);
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset();
    check_val("rst_x_pos", int'(x_pos), X0);
    check_val("rst_y_pos", int'(y_pos), Y0);
    check_val("rst_chk_x", int'(chk_x), X0);
    check_val("rst_chk_req", int'(chk_req), 0);
    check_val("rst_moved", int'(moved), 0);
    check_val("rst_blocked", int'(blocked), 0);
    ex = X0; ey = Y0;

    // right, acked clear: one query per two frames
    set_btn(0, 0, 0, 1);
    move_period();
    check_val("right1_req_count", req_count, 1);
    check_val("right1_chk_x", last_cx, ex + 4);
    check_val("right1_chk_y", last_cy, ey);
    check_val("right1_x_pos", int'(x_pos), ex + 4);
    check_val("right1_moved", moved_count, 1);
    move_period();
    ex = ex + 8;
    check_val("right2_req_count", req_count, 2);
    check_val("right2_x_pos", int'(x_pos), ex);
    check_val("right2_moved", moved_count, 2);

    // up + right together
    set_btn(1, 0, 0, 1);
    move_period();
`ifdef USER_DIAG_MOVE_EN
    ex = ex + 4;
`endif
    ey = ey - 4;
    check_val("upright_chk_x", last_cx, ex);
    check_val("upright_chk_y", last_cy, ey);
    check_val("upright_x_pos", int'(x_pos), ex);
    check_val("upright_y_pos", int'(y_pos), ey);

    // up + down cancel: no query
    base_req = req_count;
    set_btn(1, 1, 0, 0);
    move_period();
    check_val("updown_no_req", req_count - base_req, 0);
    check_val("updown_y_pos", int'(y_pos), ey);

    // left, checker reports a collision
    base_mov = moved_count;
    resp_blocked = 1'b1;
    set_btn(0, 0, 1, 0);
    move_period();
    check_val("leftblk_chk_x", last_cx, ex - 4);
    check_val("leftblk_x_pos", int'(x_pos), ex);
    check_val("leftblk_blocked", int'(blocked), 1);
    check_val("leftblk_moved", moved_count - base_mov, 0);
    resp_blocked = 1'b0;
    move_period();
    ex = ex - 4;
    check_val("leftclr_x_pos", int'(x_pos), ex);
    check_val("leftclr_blocked", int'(blocked), 0);

    // checker never answers: timeout
    ack_en = 1'b0;
    base_cyc = req_cycles;
    base_mov = moved_count;
    set_btn(0, 1, 0, 0);
    move_period();
    repeat (12) @(negedge pclk);
    check_val("tmo_req_cycles", req_cycles - base_cyc, 15);
    check_val("tmo_chk_req", int'(chk_req), 0);
    check_val("tmo_blocked", int'(blocked), 1);
    check_val("tmo_y_pos", int'(y_pos), ey);
    check_val("tmo_moved", moved_count - base_mov, 0);

    // reset while a query is outstanding, then a stale ack
    frame();
    @(negedge pclk);
    vsync_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge pclk);
      if (chk_req) seen = 1'b1;
    end
    check_val("midrst_req_seen", int'(seen), 1);
    rst_n = 1'b0;
    vsync_in = 1'b0;
    @(negedge pclk);
    check_val("midrst_req_drop", int'(chk_req), 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    base_mov = moved_count;
    resp_blocked = 1'b1;
    @(posedge pclk);
    #1 late_ack = 1'b1;
    @(posedge pclk);
    #1 late_ack = 1'b0;
    repeat (4) @(negedge pclk);
    resp_blocked = 1'b0;
    check_val("stale_ack_blocked", int'(blocked), 0);
    check_val("stale_ack_x_pos", int'(x_pos), X0);
    check_val("stale_ack_moved", moved_count - base_mov, 0);
    ex = X0; ey = Y0;

    // walk right up to 922, then saturate at 924
    set_btn(0, 0, 0, 1);
    for (int i = 0; i < 205; i++) move_period();
    check_val("walk_x_pos", int'(x_pos), 922);
    move_period();
    check_val("sat_chk_x", last_cx, 924);
    check_val("sat_x_pos", int'(x_pos), 924);
    base_req = req_count;
    base_mov = moved_count;
    move_period();
    check_val("edge_no_req", req_count - base_req, 0);
    check_val("edge_no_move", moved_count - base_mov, 0);
    check_val("edge_x_pos", int'(x_pos), 924);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/user_pos_ctl.md
Name: user_pos_ctl

Overview:
- Upstream stage of the user-sprite renderer: produces the x_pos/y_pos pair (12-bit each) that the user-drawing stage consumes.
- Once per N frames, samples debounced direction buttons and computes a candidate position. It then clamps the candidate to the screen and queries the maze obstacle checker over a req/ack handshake.
- Commits the new position only if the checker reports no collision, so downstream always sees a legal, collision-free position.

Parameters:
- X_INIT, 100, x_pos after reset
- Y_INIT, 100, y_pos after reset
- STEP, 4, pixels moved per move tick (1..63)
- MOVE_DIV, 2, frames per move tick (1..15)
- X_MAX, 924, largest legal x_pos (screen width 1024 minus sprite width 100)
- Y_MAX, 668, largest legal y_pos (768 minus 100)
- ACK_TIMEOUT, 15, cycles to wait for chk_ack before treating the query as blocked

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- vsync_in  in  1  vsync from timing chain; rising edge = frame tick
- btn_up  in  1  debounced level, active-high
- btn_down  in  1  debounced level, active-high
- btn_left  in  1  debounced level, active-high
- btn_right  in  1  debounced level, active-high
- chk_ack  in  1  checker response valid, 1-cycle pulse
- chk_blocked  in  1  collision result, valid only when chk_ack=1
- chk_req  out  1  query request, level held until ack or timeout
- chk_x  out  12  candidate x, stable while chk_req=1
- chk_y  out  12  candidate y, stable while chk_req=1
- x_pos  out  12  committed x position
- y_pos  out  12  committed y position
- moved  out  1  1-cycle pulse on the cycle x_pos/y_pos change
- blocked  out  1  sticky flag: last query was blocked or timed out

Behaviour:
- Reset (rst_n=0 at clock edge):
  - x_pos=X_INIT, y_pos=Y_INIT; chk_req=0; chk_x=X_INIT; chk_y=Y_INIT; moved=0; blocked=0.
  - Frame divider=0, vsync edge register=0, timeout counter=0, FSM=IDLE.
- Reset mid-query: chk_req drops on the next edge. A chk_ack arriving after reset is ignored.
- Frame tick: one-cycle pulse on the cycle after vsync_in is seen going 0->1, using a registered previous value.
- Frame divider: counts frame ticks 0..MOVE_DIV-1. A move tick fires when the divider wraps to 0.
- FSM states:
  - IDLE -> CALC on move tick.
  - CALC (1 cycle): latch buttons and compute the candidate.
    - Up/down cancel each other; left/right cancel each other.
    - Y axis: up gives y-STEP, saturated at 0; down gives y+STEP, saturated at Y_MAX.
    - X axis: left/right handled the same way, saturating at 0 and X_MAX.
    - Arithmetic in 13 bits before saturation, so nothing wraps.
    - If candidate == current position (no buttons, or at the boundary): -> IDLE, no query, blocked unchanged.
    - Otherwise drive chk_x/chk_y and -> QUERY.
  - QUERY: chk_req=1 and the timeout counter increments each cycle.
    - chk_ack=1: capture chk_blocked into blocked and -> COMMIT.
    - Counter reaches ACK_TIMEOUT with no ack: blocked=1 and -> IDLE.
    - chk_ack in the same cycle as the timeout: the ack wins.
  - COMMIT (1 cycle): chk_req=0.
    - If not blocked: x_pos<=chk_x, y_pos<=chk_y, moved=1.
    - -> IDLE.
- Move tick arriving in any state other than IDLE is dropped; no queueing.
- Latency: a move tick to the x_pos/y_pos update is 3 + ack-delay cycles. Position is therefore stable well before the next active frame.
- x_pos/y_pos change only in COMMIT, never mid-query.

Optional Feature:
- Macro: USER_DIAG_MOVE_EN.
- Defined: both axes move in the same tick (diagonal), checked as one candidate. If the candidate is blocked, neither axis moves.
- Undefined: single axis only, with priority up > down > left > right. The lower-priority axis is ignored that tick.

Test Plan:
- Reset with rst_n=0 for 3 cycles -> x_pos=100, y_pos=100, chk_req=0, moved=0, blocked=0.
- btn_right held, MOVE_DIV=2, checker acks blocked=0 after 2 cycles -> exactly one chk_req per 2 vsync edges with chk_x=104, chk_y=100. x_pos=104 then 108, with one moved pulse each.
- x_pos=922, btn_right, STEP=4 -> chk_x=924 (saturated). Next tick with x_pos=924: no chk_req, no move.
- btn_left with chk_blocked=1 on ack -> x_pos unchanged, blocked=1, moved=0. Next query acked clear -> blocked=0.
- Checker never acks -> chk_req high for exactly ACK_TIMEOUT cycles then low, blocked=1, position unchanged.
- btn_up+btn_right at (100,100), STEP=4:
  - With USER_DIAG_MOVE_EN: candidate (104,96).
  - Without it: candidate (100,96).
  - btn_up+btn_down together: no query.
